// File: rtl/exu_pkg.sv
// exu_pkg: shared types for the EXU issue controller.
//   specinst_e    - special-instruction codes carried with each issue
//   issue_state_e - issue register occupancy
//   REG_IDX_W     - architectural register index width
//   issue_ctrl_t  - control part of the issue payload (data fields live beside it)
package exu_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [2:0] {
        SPEC_NONE  = 3'd0,
        SPEC_JAL   = 3'd1,
        SPEC_JALR  = 3'd2,
        SPEC_AUIPC = 3'd3,
        SPEC_LUI   = 3'd4
    } specinst_e;

    typedef enum logic {
        ISSUE_EMPTY = 1'b0,
        ISSUE_FULL  = 1'b1
    } issue_state_e;

    typedef struct packed {
        logic                 ers1;
        logic                 ers2;
        logic [2:0]           specinst;
        logic [REG_IDX_W-1:0] rd;
        logic                 rd_we;
    } issue_ctrl_t;

endpackage

// File: rtl/exu_scoreboard.sv
// exu_scoreboard: one pending bit per architectural register.
// Optional feature macro: EXU_WB_FWD_EN (writeback bypass of the hazard check).
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   set_en_i/set_idx_i        mark a destination in flight (issue accept)
//   wb_en_i/wb_idx_i          writeback clears its destination
//   fl_en_i/fl_idx_i          flush clears the killed instruction's destination
//   rs1/rs2/rd lookup         indices + use enables of the decoding instruction
//   hazard_o                  RAW/WAW conflict with a pending register
//   rs1_fwd_o/rs2_fwd_o       source matches this cycle's writeback (bypass)
module exu_scoreboard
    import exu_pkg::*;
#(
    parameter int REG_NUM = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 set_en_i,
    input  logic [REG_IDX_W-1:0] set_idx_i,
    input  logic                 wb_en_i,
    input  logic [REG_IDX_W-1:0] wb_idx_i,
    input  logic                 fl_en_i,
    input  logic [REG_IDX_W-1:0] fl_idx_i,
    input  logic                 ers1_i,
    input  logic [REG_IDX_W-1:0] rs1_idx_i,
    input  logic                 ers2_i,
    input  logic [REG_IDX_W-1:0] rs2_idx_i,
    input  logic                 rd_we_i,
    input  logic [REG_IDX_W-1:0] rd_idx_i,
    output logic                 hazard_o,
    output logic                 rs1_fwd_o,
    output logic                 rs2_fwd_o
);

    logic [REG_NUM-1:0] pend_q;
    logic [REG_NUM-1:0] pend_d;
    logic [REG_NUM-1:0] set_vec;
    logic [REG_NUM-1:0] clr_vec;
    logic               rd_fwd;

    // Clears are applied first so a same-cycle set of the same index wins.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en_i) set_vec[set_idx_i] = 1'b1;
        if (wb_en_i)  clr_vec[wb_idx_i]  = 1'b1;
        if (fl_en_i)  clr_vec[fl_idx_i]  = 1'b1;
        pend_d    = (pend_q & ~clr_vec) | set_vec;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) pend_q <= '0;
        else          pend_q <= pend_d;
    end

`ifdef EXU_WB_FWD_EN
    assign rs1_fwd_o = wb_en_i && (wb_idx_i != '0) && (wb_idx_i == rs1_idx_i);
    assign rs2_fwd_o = wb_en_i && (wb_idx_i != '0) && (wb_idx_i == rs2_idx_i);
    assign rd_fwd    = wb_en_i && (wb_idx_i != '0) && (wb_idx_i == rd_idx_i);
`else
    assign rs1_fwd_o = 1'b0;
    assign rs2_fwd_o = 1'b0;
    assign rd_fwd    = 1'b0;
`endif

    assign hazard_o = (ers1_i  && pend_q[rs1_idx_i] && !rs1_fwd_o) ||
                      (ers2_i  && pend_q[rs2_idx_i] && !rs2_fwd_o) ||
                      (rd_we_i && pend_q[rd_idx_i]  && !rd_fwd);

endmodule

// File: rtl/exu_issue_ctrl.sv
// exu_issue_ctrl: single-entry issue register between decode and EXU operand select.
// Stalls decode on RAW/WAW hazards against in-flight destinations and counts
// hazard stall cycles (saturating).
// Optional feature macro: EXU_WB_FWD_EN (bypass writeback data into the issue register).
// Ports:
//   clk_i, rst_n_i              clock, async active-low reset
//   dec_*                       decoded instruction + valid/ready handshake
//   rf_rs1_data_i/rf_rs2_data_i register-file read data for the dec indices
//   exu_*                       registered issue payload + valid/ready handshake
//   wb_valid_i/wb_rd_i/wb_data_i writeback
//   flush_i                     kill the issue register
//   stall_o, stall_cnt_o        decode stall and hazard-stall counter
//
// state       | meaning
// ISSUE_EMPTY | issue register holds nothing, exu_valid_o = 0
// ISSUE_FULL  | issue register holds an instruction, exu_valid_o = 1
module exu_issue_ctrl
    import exu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int REG_NUM    = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  dec_valid_i,
    output logic                  dec_ready_o,
    input  logic [REG_IDX_W-1:0]  dec_rs1_idx_i,
    input  logic [REG_IDX_W-1:0]  dec_rs2_idx_i,
    input  logic                  dec_ers1_i,
    input  logic                  dec_ers2_i,
    input  logic [REG_IDX_W-1:0]  dec_rd_i,
    input  logic                  dec_rd_we_i,
    input  logic [2:0]            dec_specinst_i,
    input  logic [DATA_WIDTH-1:0] dec_pc_i,
    input  logic [DATA_WIDTH-1:0] dec_imme_i,
    input  logic [DATA_WIDTH-1:0] rf_rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rf_rs2_data_i,
    output logic                  exu_valid_o,
    input  logic                  exu_ready_i,
    output logic                  exu_ers1_o,
    output logic                  exu_ers2_o,
    output logic [2:0]            exu_specinst_o,
    output logic [DATA_WIDTH-1:0] exu_rs1_o,
    output logic [DATA_WIDTH-1:0] exu_rs2_o,
    output logic [DATA_WIDTH-1:0] exu_pc_o,
    output logic [DATA_WIDTH-1:0] exu_imme_o,
    output logic [REG_IDX_W-1:0]  exu_rd_o,
    output logic                  exu_rd_we_o,
    input  logic                  wb_valid_i,
    input  logic [REG_IDX_W-1:0]  wb_rd_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    issue_state_e          state_q, state_d;
    issue_ctrl_t           ctrl_q;
    logic [DATA_WIDTH-1:0] rs1_q, rs2_q, pc_q, imme_q;
    logic [CNT_WIDTH-1:0]  stall_cnt_q;
    logic                  hazard, accept, rs1_fwd, rs2_fwd, hazard_stall;

    exu_scoreboard #(.REG_NUM(REG_NUM)) u_sb (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .set_en_i  (accept && dec_rd_we_i),
        .set_idx_i (dec_rd_i),
        .wb_en_i   (wb_valid_i),
        .wb_idx_i  (wb_rd_i),
        .fl_en_i   (flush_i && (state_q == ISSUE_FULL) && ctrl_q.rd_we),
        .fl_idx_i  (ctrl_q.rd),
        .ers1_i    (dec_ers1_i),
        .rs1_idx_i (dec_rs1_idx_i),
        .ers2_i    (dec_ers2_i),
        .rs2_idx_i (dec_rs2_idx_i),
        .rd_we_i   (dec_rd_we_i),
        .rd_idx_i  (dec_rd_i),
        .hazard_o  (hazard),
        .rs1_fwd_o (rs1_fwd),
        .rs2_fwd_o (rs2_fwd)
    );

    always_comb begin
        dec_ready_o = !flush_i && !hazard && ((state_q == ISSUE_EMPTY) || exu_ready_i);
        accept      = dec_valid_i && dec_ready_o;
        state_d     = state_q;
        if (flush_i) begin
            state_d = ISSUE_EMPTY;
        end else begin
            case (state_q)
                ISSUE_EMPTY: if (accept) state_d = ISSUE_FULL;
                ISSUE_FULL:  if (exu_ready_i && !accept) state_d = ISSUE_EMPTY;
                default:     state_d = ISSUE_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ISSUE_EMPTY;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            pc_q   <= '0;
            imme_q <= '0;
        end else if (accept) begin
            ctrl_q <= '{ers1: dec_ers1_i, ers2: dec_ers2_i, specinst: dec_specinst_i,
                        rd: dec_rd_i, rd_we: dec_rd_we_i};
            rs1_q  <= rs1_fwd ? wb_data_i : rf_rs1_data_i;
            rs2_q  <= rs2_fwd ? wb_data_i : rf_rs2_data_i;
            pc_q   <= dec_pc_i;
            imme_q <= dec_imme_i;
        end
    end

    // Flush takes precedence over a coincident hazard when attributing a stall.
    assign hazard_stall = dec_valid_i && hazard && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else if (hazard_stall && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign exu_valid_o    = (state_q == ISSUE_FULL);
    assign exu_ers1_o     = ctrl_q.ers1;
    assign exu_ers2_o     = ctrl_q.ers2;
    assign exu_specinst_o = ctrl_q.specinst;
    assign exu_rd_o       = ctrl_q.rd;
    assign exu_rd_we_o    = ctrl_q.rd_we;
    assign exu_rs1_o      = rs1_q;
    assign exu_rs2_o      = rs2_q;
    assign exu_pc_o       = pc_q;
    assign exu_imme_o     = imme_q;
    assign stall_o        = dec_valid_i && !dec_ready_o;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// tb_exu_issue_ctrl: directed table, hand-written corner sequences and
// randomized traffic checked against a behavioural model of the issue stage.
// Honors EXU_WB_FWD_EN like the design.
module tb_exu_issue_ctrl;

    localparam int DW = 64;
    localparam int RN = 32;
    localparam int CW = 4;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;
`ifdef EXU_WB_FWD_EN
    localparam int unsigned EXP_CNT_A = 2;
`else
    localparam int unsigned EXP_CNT_A = 3;
`endif

    typedef logic [299:0] w_t;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          dec_valid_i, dec_ready_o;
    logic [4:0]    dec_rs1_idx_i, dec_rs2_idx_i, dec_rd_i;
    logic          dec_ers1_i, dec_ers2_i, dec_rd_we_i;
    logic [2:0]    dec_specinst_i;
    logic [DW-1:0] dec_pc_i, dec_imme_i, rf_rs1_data_i, rf_rs2_data_i;
    logic          exu_valid_o, exu_ready_i;
    logic          exu_ers1_o, exu_ers2_o, exu_rd_we_o;
    logic [2:0]    exu_specinst_o;
    logic [DW-1:0] exu_rs1_o, exu_rs2_o, exu_pc_o, exu_imme_o;
    logic [4:0]    exu_rd_o;
    logic          wb_valid_i;
    logic [4:0]    wb_rd_i;
    logic [DW-1:0] wb_data_i;
    logic          flush_i, stall_o;
    logic [CW-1:0] stall_cnt_o;

    exu_issue_ctrl #(.DATA_WIDTH(DW), .REG_NUM(RN), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_rs1_idx_i(dec_rs1_idx_i), .dec_rs2_idx_i(dec_rs2_idx_i),
        .dec_ers1_i(dec_ers1_i), .dec_ers2_i(dec_ers2_i),
        .dec_rd_i(dec_rd_i), .dec_rd_we_i(dec_rd_we_i), .dec_specinst_i(dec_specinst_i),
        .dec_pc_i(dec_pc_i), .dec_imme_i(dec_imme_i),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .exu_valid_o(exu_valid_o), .exu_ready_i(exu_ready_i),
        .exu_ers1_o(exu_ers1_o), .exu_ers2_o(exu_ers2_o), .exu_specinst_o(exu_specinst_o),
        .exu_rs1_o(exu_rs1_o), .exu_rs2_o(exu_rs2_o), .exu_pc_o(exu_pc_o),
        .exu_imme_o(exu_imme_o), .exu_rd_o(exu_rd_o), .exu_rd_we_o(exu_rd_we_o),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .flush_i(flush_i), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_total = 0;
    logic pre_rdy, pre_stall;

    task automatic chk(input string name, input w_t act, input w_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit            m_pend[RN];
    bit            m_valid;
    logic          m_ers1, m_ers2, m_rd_we;
    logic [2:0]    m_spec;
    logic [4:0]    m_rd;
    logic [DW-1:0] m_rs1, m_rs2, m_pc, m_imme;
    int unsigned   m_cnt;

    task automatic m_reset();
        for (int i = 0; i < RN; i++) m_pend[i] = 1'b0;
        m_valid = 1'b0; m_ers1 = 1'b0; m_ers2 = 1'b0; m_rd_we = 1'b0;
        m_spec = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_pc = '0; m_imme = '0;
        m_cnt = 0;
    endtask

    function automatic bit fwd_hit(input logic [4:0] idx);
`ifdef EXU_WB_FWD_EN
        return wb_valid_i && (wb_rd_i != 5'd0) && (wb_rd_i == idx);
`else
        return (idx == 5'd0) && 1'b0;
`endif
    endfunction

    function automatic bit m_blocked(input logic used, input logic [4:0] idx);
        return used && m_pend[idx] && !fwd_hit(idx);
    endfunction

    function automatic bit m_hazard();
        return m_blocked(dec_ers1_i, dec_rs1_idx_i) || m_blocked(dec_ers2_i, dec_rs2_idx_i) ||
               m_blocked(dec_rd_we_i, dec_rd_i);
    endfunction

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v;
        for (int i = 0; i < RN; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // One clock: inputs already driven by the caller just after the previous edge.
    task automatic cycle();
        bit hz, rdy, acc;
        #2;
        hz  = m_hazard();
        rdy = !flush_i && !hz && (!m_valid || exu_ready_i);
        acc = dec_valid_i && rdy;
        pre_rdy   = dec_ready_o;
        pre_stall = stall_o;
        chk("dec_ready", w_t'(dec_ready_o), w_t'(rdy));
        chk("stall", w_t'(stall_o), w_t'(dec_valid_i && !rdy));
        @(posedge clk_i);
        if (flush_i && m_valid && m_rd_we) m_pend[m_rd] = 1'b0;
        if (wb_valid_i) m_pend[wb_rd_i] = 1'b0;
        if (acc && dec_rd_we_i) m_pend[dec_rd_i] = 1'b1;
        m_pend[0] = 1'b0;
        if (dec_valid_i && hz && !flush_i && m_cnt < CNT_MAX) m_cnt++;
        if (flush_i) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_ers1 = dec_ers1_i; m_ers2 = dec_ers2_i; m_spec = dec_specinst_i;
            m_rd = dec_rd_i; m_rd_we = dec_rd_we_i; m_pc = dec_pc_i; m_imme = dec_imme_i;
            m_rs1 = fwd_hit(dec_rs1_idx_i) ? wb_data_i : rf_rs1_data_i;
            m_rs2 = fwd_hit(dec_rs2_idx_i) ? wb_data_i : rf_rs2_data_i;
        end else if (exu_ready_i) m_valid = 1'b0;
        #1;
        chk("exu_valid", w_t'(exu_valid_o), w_t'(m_valid));
        chk("exu_fields",
            w_t'({exu_ers1_o, exu_ers2_o, exu_specinst_o, exu_rs1_o, exu_rs2_o, exu_pc_o, exu_imme_o, exu_rd_o, exu_rd_we_o}),
            w_t'({m_ers1, m_ers2, m_spec, m_rs1, m_rs2, m_pc, m_imme, m_rd, m_rd_we}));
        chk("pend", w_t'(dut.u_sb.pend_q), w_t'(m_pend_vec()));
        chk("stall_cnt", w_t'(stall_cnt_o), w_t'(m_cnt));
    endtask

    task automatic idle();
        dec_valid_i = 0; dec_rs1_idx_i = 0; dec_rs2_idx_i = 0; dec_ers1_i = 0; dec_ers2_i = 0;
        dec_rd_i = 0; dec_rd_we_i = 0; dec_specinst_i = 0; dec_pc_i = 0; dec_imme_i = 0;
        rf_rs1_data_i = 0; rf_rs2_data_i = 0; exu_ready_i = 1; wb_valid_i = 0; wb_rd_i = 0;
        wb_data_i = 0; flush_i = 0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk_i);
        #3 rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n_i = 1'b0;
        m_reset();
        release_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic dv; logic ers1; logic [4:0] rs1; logic [4:0] rd; logic rd_we;
        logic [63:0] pc; logic [63:0] imme; logic wbv; logic [4:0] wbrd;
        logic e_rdy; logic e_valid; logic [63:0] e_pc; logic [31:0] e_pend; logic [3:0] e_cnt;
    } vec_t;
    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 64'h0,    64'h0,  1'b0, 5'd0, 1'b1, 1'b0, 64'h0,    32'h0,  4'd0};
        tbl[1] = '{1'b1, 1'b0, 5'd0, 5'd5, 1'b1, 64'h1000, 64'h10, 1'b0, 5'd0, 1'b1, 1'b1, 64'h1000, 32'h20, 4'd0};
        tbl[2] = '{1'b1, 1'b1, 5'd5, 5'd6, 1'b1, 64'h1004, 64'h4,  1'b0, 5'd0, 1'b0, 1'b0, 64'h1000, 32'h20, 4'd1};
        tbl[3] = '{1'b1, 1'b1, 5'd5, 5'd6, 1'b1, 64'h1004, 64'h4,  1'b0, 5'd0, 1'b0, 1'b0, 64'h1000, 32'h20, 4'd2};
        tbl[4] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 64'h0,    64'h0,  1'b1, 5'd5, 1'b1, 1'b0, 64'h1000, 32'h0,  4'd2};
        tbl[5] = '{1'b1, 1'b1, 5'd5, 5'd6, 1'b1, 64'h1004, 64'h4,  1'b0, 5'd0, 1'b1, 1'b1, 64'h1004, 32'h40, 4'd2};
        tbl[6] = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 64'h2000, 64'h8,  1'b0, 5'd0, 1'b1, 1'b1, 64'h2000, 32'h40, 4'd2};
        tbl[7] = '{1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 64'h2004, 64'h0,  1'b0, 5'd0, 1'b1, 1'b1, 64'h2004, 32'h40, 4'd2};
        tbl[8] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 64'h0,    64'h0,  1'b1, 5'd6, 1'b1, 1'b0, 64'h2004, 32'h0,  4'd2};

        // reset state
        do_reset();
        #2;
        chk("rst_ready", w_t'(dec_ready_o), w_t'(1));
        chk("rst_valid", w_t'(exu_valid_o), w_t'(0));
        chk("rst_fields", w_t'({exu_rs1_o, exu_pc_o, exu_imme_o, exu_rd_o, exu_rd_we_o}), w_t'(0));
        chk("rst_pend", w_t'(dut.u_sb.pend_q), w_t'(0));
        chk("rst_cnt", w_t'(stall_cnt_o), w_t'(0));
        @(posedge clk_i); #1;

        for (int i = 0; i < 9; i++) begin
            idle();
            dec_valid_i = tbl[i].dv; dec_ers1_i = tbl[i].ers1; dec_rs1_idx_i = tbl[i].rs1;
            dec_rd_i = tbl[i].rd; dec_rd_we_i = tbl[i].rd_we; dec_pc_i = tbl[i].pc;
            dec_imme_i = tbl[i].imme; wb_valid_i = tbl[i].wbv; wb_rd_i = tbl[i].wbrd;
            cycle();
            chk($sformatf("tbl%0d_rdy", i), w_t'(pre_rdy), w_t'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_valid", i), w_t'(exu_valid_o), w_t'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_pc", i), w_t'(exu_pc_o), w_t'(tbl[i].e_pc));
            chk($sformatf("tbl%0d_pend", i), w_t'(dut.u_sb.pend_q), w_t'(tbl[i].e_pend));
            chk($sformatf("tbl%0d_cnt", i), w_t'(stall_cnt_o), w_t'(tbl[i].e_cnt));
        end

        // RAW stall released by writeback
        do_reset();
        dec_valid_i = 1; dec_rd_i = 5; dec_rd_we_i = 1; dec_pc_i = 64'h3000;
        cycle();
        dec_ers1_i = 1; dec_rs1_idx_i = 5; dec_rd_i = 9; dec_pc_i = 64'h3004;
        rf_rs1_data_i = 64'h1111;
        cycle();
        chk("raw_stall1", w_t'(pre_stall), w_t'(1));
        cycle();
        chk("raw_stall2", w_t'(pre_stall), w_t'(1));
        wb_valid_i = 1; wb_rd_i = 5; wb_data_i = 64'hBEEF;
        cycle();
`ifdef EXU_WB_FWD_EN
        chk("wb_cycle_rdy", w_t'(pre_rdy), w_t'(1));
        chk("fwd_valid", w_t'(exu_valid_o), w_t'(1));
        chk("fwd_rs1", w_t'(exu_rs1_o), w_t'(64'hBEEF));
`else
        chk("wb_cycle_rdy", w_t'(pre_rdy), w_t'(0));
        wb_valid_i = 0;
        cycle();
        chk("post_wb_rdy", w_t'(pre_rdy), w_t'(1));
        chk("post_wb_valid", w_t'(exu_valid_o), w_t'(1));
        chk("post_wb_rs1", w_t'(exu_rs1_o), w_t'(64'h1111));
`endif
        chk("raw_cnt", w_t'(stall_cnt_o), w_t'(EXP_CNT_A));

        // backpressure: hold while FULL
        idle();
        dec_valid_i = 1; dec_rd_i = 10; dec_rd_we_i = 1; dec_pc_i = 64'h4000; exu_ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_rdy", w_t'(pre_rdy), w_t'(0));
            chk("bp_stall", w_t'(pre_stall), w_t'(1));
            chk("bp_pc_hold", w_t'(exu_pc_o), w_t'(64'h3004));
            chk("bp_cnt", w_t'(stall_cnt_o), w_t'(EXP_CNT_A));
        end
        exu_ready_i = 1;
        cycle();
        chk("bp_release_pc", w_t'(exu_pc_o), w_t'(64'h4000));

        // flush kills rd=7 and its pending bit
        idle();
        dec_valid_i = 1; dec_rd_i = 7; dec_rd_we_i = 1; dec_pc_i = 64'h5000;
        cycle();
        chk("fl_pend7_set", w_t'(dut.u_sb.pend_q[7]), w_t'(1));
        idle();
        flush_i = 1;
        cycle();
        chk("fl_valid", w_t'(exu_valid_o), w_t'(0));
        chk("fl_pend7_clr", w_t'(dut.u_sb.pend_q[7]), w_t'(0));
        idle();
        dec_valid_i = 1; dec_ers1_i = 1; dec_rs1_idx_i = 7; dec_rd_i = 11; dec_rd_we_i = 1;
        dec_pc_i = 64'h5004;
        cycle();
        chk("fl_next_rdy", w_t'(pre_rdy), w_t'(1));
        chk("fl_next_pc", w_t'(exu_pc_o), w_t'(64'h5004));

        // async reset while FULL with pending bits
        idle();
        chk("ar_pre_pend", w_t'(dut.u_sb.pend_q != 32'h0), w_t'(1));
        #2 rst_n_i = 1'b0;
        #1;
        chk("ar_valid", w_t'(exu_valid_o), w_t'(0));
        chk("ar_fields", w_t'({exu_ers1_o, exu_ers2_o, exu_specinst_o, exu_rs1_o, exu_rs2_o,
                               exu_pc_o, exu_imme_o, exu_rd_o, exu_rd_we_o}), w_t'(0));
        chk("ar_pend", w_t'(dut.u_sb.pend_q), w_t'(0));
        chk("ar_cnt", w_t'(stall_cnt_o), w_t'(0));
        m_reset();
        release_reset();

        // randomized traffic, reset between bursts so the saturating counter stays observable
        for (int b = 0; b < 4; b++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                dec_valid_i    = ($urandom_range(0, 99) < 70);
                dec_ers1_i     = ($urandom_range(0, 1) == 1);
                dec_ers2_i     = ($urandom_range(0, 1) == 1);
                dec_rd_we_i    = ($urandom_range(0, 99) < 75);
                dec_rs1_idx_i  = 5'($urandom_range(0, 7));
                dec_rs2_idx_i  = 5'($urandom_range(0, 7));
                dec_rd_i       = 5'($urandom_range(0, 7));
                dec_specinst_i = 3'($urandom_range(0, 4));
                dec_pc_i       = {$urandom, $urandom};
                dec_imme_i     = {$urandom, $urandom};
                rf_rs1_data_i  = {$urandom, $urandom};
                rf_rs2_data_i  = {$urandom, $urandom};
                exu_ready_i    = ($urandom_range(0, 99) < 70);
                wb_valid_i     = ($urandom_range(0, 99) < 35);
                wb_rd_i        = 5'($urandom_range(0, 7));
                wb_data_i      = {$urandom, $urandom};
                flush_i        = ($urandom_range(0, 99) < 5);
                cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
